code_word_tx: RTL and testbench
===============================

Name: code_word_tx

Overview:
- Encoder/transmitter counterpart of the status decoder.
- Accepts decoded status tuples (match flag, 2-bit class) on a valid/ready input and emits packed CODE_W-bit code words on a valid/ready output.
- A matched status is emitted as the shared package constant MATCH_CODE. A non-match is emitted as a tagged word with a rolling sequence number.
- Includes a 2-entry output buffer so the upstream is never combinationally stalled by the downstream.

Parameters:
- CODE_W, 6, code word width; must be >= 3+SEQ_W.
- SEQ_W, 3, sequence tag width.
- MATCH_CODE, 6'h03, code emitted for a matched status; its MSB (bit CODE_W-1) must be 0.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  status tuple valid.
- in_ready  output  1  block can accept a tuple this cycle.
- in_match  input  1  status is a match.
- in_class  input  2  status class (ignored when in_match=1).
- seq_clr  input  1  synchronous clear of the sequence tag.
- out_valid  output  1  out_code valid.
- out_ready  input  1  downstream accepts out_code.
- out_code  output  CODE_W  encoded word.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values: out_valid=0, out_code=0, in_ready=1, seq=0, buffer state EMPTY.
- Transfer rules: input transfer when in_valid&in_ready; output transfer when out_valid&out_ready.
- Encoding at input transfer:
  - in_match=1 -> word=MATCH_CODE; seq unchanged.
  - in_match=0 -> word={1'b1, in_class, zero-pad, seq}, with seq in the LSBs; seq then increments, wrapping 2^SEQ_W-1 -> 0.
  - Non-match words therefore never equal MATCH_CODE (MSB differs).
- Latency: a word accepted in cycle N is presented on out_code with out_valid=1 in cycle N+1 at the earliest. There is no combinational in->out path.
- Buffer FSM states: EMPTY, ONE, TWO. out_code always shows the head entry.
  - EMPTY: push -> ONE.
  - ONE: push only -> TWO; pop only -> EMPTY; push+pop -> ONE (new word becomes head next cycle).
  - TWO: in_ready=0; pop -> ONE (second entry becomes head).
- in_ready is registered: 1 in EMPTY/ONE, 0 in TWO.
- Words emerge in acceptance order. No loss or duplication under any out_ready pattern.
- Holding rule: out_code and out_valid stay stable while out_valid=1 and out_ready=0.
- seq_clr=1: seq becomes 0 next cycle.
  - If a non-match is accepted in the same cycle, that word carries the pre-clear seq, and seq is 0 afterwards (clear wins over increment).
- in_valid while in_ready=0: ignored. No state change, seq does not advance.
- Reset asserted mid-operation: buffered words are discarded immediately (asynchronous); all outputs return to reset values.

Optional Feature:
- Macro CODE_WORD_TX_STATS_EN.
- When defined: adds output match_cnt[7:0], a count of matched tuples accepted at the input. It saturates at 8'hFF, resets to 0, and is unaffected by seq_clr.
- When undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset then idle -> out_valid=0, in_ready=1, out_code=6'h00.
- Push match, then non-match class=2'b10, with out_ready=1 -> out_code 6'h03, then 6'b110000 (seq=0), each 1 cycle after acceptance.
- Hold out_ready=0 and push 3 tuples -> in_ready drops after the 2nd. The 3rd is held upstream. Release -> 3 words in order, seq tags 0,1,2 on non-matches.
- 9 consecutive non-match class=0 -> tags 0..7 then 0 (wrap). Assert seq_clr coincident with the 4th push -> 4th word carries seq=3, 5th carries seq=0.
- Simultaneous push+pop in ONE for 10 cycles at full rate -> one word per cycle, no bubbles, in_ready stays 1.
- Deassert rst_n while in TWO -> out_valid=0 same cycle. After release -> in_ready=1, first non-match carries seq=0. With CODE_WORD_TX_STATS_EN: 300 matches -> match_cnt=8'hFF.

Source files
------------

// File: rtl/code_word_tx.sv
// Status-tuple encoder: match -> MATCH_CODE, non-match -> tagged word with a rolling sequence
// number, delivered through a registered 2-entry output buffer. Optional macro: CODE_WORD_TX_STATS_EN.
module code_word_tx #(
   parameter int                CODE_W     = 6,
   parameter int                SEQ_W      = 3,
   parameter logic [CODE_W-1:0] MATCH_CODE = 6'h03
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_match,
   input  logic [1:0]        in_class,
   input  logic              seq_clr,
   output logic              out_valid,
   input  logic              out_ready,
`ifdef CODE_WORD_TX_STATS_EN
   output logic [7:0]        match_cnt,
`endif
   output logic [CODE_W-1:0] out_code
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_in_ready;
   logic              r_out_valid;
   logic [CODE_W-1:0] r_head;
   logic [CODE_W-1:0] r_tail;
   logic [SEQ_W-1:0]  r_seq;
   logic [SEQ_W-1:0]  w_seq_nxt;
   logic [CODE_W-1:0] w_word;
   logic              w_push;
   logic              w_pop;
   logic              w_load_head;
   logic              w_load_tail;
   logic              w_head_from_tail;

   // Tagged word layout: MSB set, class below it, zero padding, sequence tag in the LSBs.
   function automatic logic [CODE_W-1:0] f_tag_word(input logic [1:0] cls, input logic [SEQ_W-1:0] seq);
      logic [CODE_W-1:0] word;
      word                  = '0;
      word[CODE_W-1]        = 1'b1;
      word[CODE_W-2 -: 2]   = cls;
      word[SEQ_W-1:0]       = seq;
      return word;
   endfunction

   assign w_push = in_valid & r_in_ready;
   assign w_pop  = r_out_valid & out_ready;
   assign w_word = in_match ? MATCH_CODE : f_tag_word(in_class, r_seq);

   // Buffer next-state and data-movement strobes.
   always_comb begin
      w_state_nxt      = r_state;
      w_load_head      = 1'b0;
      w_load_tail      = 1'b0;
      w_head_from_tail = 1'b0;
      case (r_state)
         ST_EMPTY: begin
            if (w_push) begin
               w_state_nxt = ST_ONE;
               w_load_head = 1'b1;
            end else begin
               w_state_nxt = ST_EMPTY;
            end
         end
         ST_ONE: begin
            case ({w_push, w_pop})
               2'b10: begin
                  w_state_nxt = ST_TWO;
                  w_load_tail = 1'b1;
               end
               2'b01: begin
                  w_state_nxt = ST_EMPTY;
               end
               2'b11: begin
                  w_state_nxt = ST_ONE;
                  w_load_head = 1'b1;
               end
               default: begin
                  w_state_nxt = ST_ONE;
               end
            endcase
         end
         ST_TWO: begin
            // in_ready is low here, so only a pop can occur
            if (w_pop) begin
               w_state_nxt      = ST_ONE;
               w_head_from_tail = 1'b1;
            end else begin
               w_state_nxt = ST_TWO;
            end
         end
         default: begin
            w_state_nxt = ST_EMPTY;
         end
      endcase
   end

   // Sequence tag: clear takes priority over the post-accept increment.
   always_comb begin
      w_seq_nxt = r_seq;
      if (seq_clr) begin
         w_seq_nxt = '0;
      end else if (w_push && !in_match) begin
         w_seq_nxt = r_seq + SEQ_W'(1);
      end else begin
         w_seq_nxt = r_seq;
      end
   end

   // State register with handshake flags precomputed from the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_EMPTY;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b1;
      end else begin
         r_state     <= w_state_nxt;
         r_out_valid <= (w_state_nxt != ST_EMPTY);
         r_in_ready  <= (w_state_nxt != ST_TWO);
      end
   end

   // Head/tail storage; head always drives out_code.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_head <= '0;
         r_tail <= '0;
      end else begin
         if (w_load_head) begin
            r_head <= w_word;
         end else if (w_head_from_tail) begin
            r_head <= r_tail;
         end
         if (w_load_tail) begin
            r_tail <= w_word;
         end
      end
   end

   // Sequence tag register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_seq <= '0;
      end else begin
         r_seq <= w_seq_nxt;
      end
   end

`ifdef CODE_WORD_TX_STATS_EN
   logic [7:0] r_match_cnt;

   // Saturating count of accepted matches, independent of seq_clr.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_match_cnt <= 8'h00;
      end else if (w_push && in_match && (r_match_cnt != 8'hFF)) begin
         r_match_cnt <= r_match_cnt + 8'h01;
      end
   end

   assign match_cnt = r_match_cnt;
`endif

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_code  = r_head;

endmodule

// File: tb/tb_code_word_tx.sv
// Self-checking bench for code_word_tx: directed steps plus random traffic against a queue model.
module tb_code_word_tx;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic       in_match;
   logic [1:0] in_class;
   logic       seq_clr;
   logic       out_valid;
   logic       out_ready;
   logic [5:0] out_code;
`ifdef CODE_WORD_TX_STATS_EN
   logic [7:0] match_cnt;
`endif

   int         total;
   int         bad;
   logic [5:0] q[$];
   int         seq_m;
   int         mcnt_m;

   code_word_tx dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_match  (in_match),
      .in_class  (in_class),
      .seq_clr   (seq_clr),
      .out_valid (out_valid),
      .out_ready (out_ready),
`ifdef CODE_WORD_TX_STATS_EN
      .match_cnt (match_cnt),
`endif
      .out_code  (out_code)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: check outputs against the model, drive inputs, advance model, step past the edge.
   task automatic cyc(input logic v, input logic m, input logic [1:0] cls, input logic clr, input logic ordy);
      logic       push;
      logic       pop;
      logic [5:0] w;
      in_valid  = v;
      in_match  = m;
      in_class  = cls;
      seq_clr   = clr;
      out_ready = ordy;
      chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
      chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
      if (q.size() > 0) chk("out_code", 32'(out_code), 32'(q[0]));
`ifdef CODE_WORD_TX_STATS_EN
      chk("match_cnt", 32'(match_cnt), 32'(mcnt_m));
`endif
      push = v && (q.size() < 2);
      pop  = ordy && (q.size() > 0);
      if (pop) void'(q.pop_front());
      if (push) begin
         if (m) begin
            w = 6'h03;
            if (mcnt_m < 255) mcnt_m++;
         end else begin
            w = 6'(32 + 32'(cls) * 8 + seq_m);
            seq_m = (seq_m + 1) % 8;
         end
         q.push_back(w);
      end
      if (clr) seq_m = 0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      seq_m     = 0;
      mcnt_m    = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_match  = 1'b0;
      in_class  = 2'b00;
      seq_clr   = 1'b0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // reset then idle
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_code", 32'(out_code), 32'h00);
      cyc(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);

      // match then non-match class 2 at full rate
      cyc(1'b1, 1'b1, 2'b00, 1'b0, 1'b1);
      chk("tp2_match", 32'(out_code), 32'h03);
      cyc(1'b1, 1'b0, 2'b10, 1'b0, 1'b1);
      chk("tp2_tag", 32'(out_code), 32'b110000);
      cyc(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);

      // back-pressure: third tuple held upstream
      cyc(1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 2'b01, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 2'b00, 1'b0, 1'b0);
      chk("tp3_full", 32'(in_ready), 32'd0);
      cyc(1'b1, 1'b0, 2'b11, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 2'b11, 1'b0, 1'b0);
      chk("tp3_hold_code", 32'(out_code), 32'b101000);
      repeat (5) cyc(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);

      // nine non-matches wrap the tag; then clear coincident with 4th push
      cyc(1'b0, 1'b0, 2'b00, 1'b1, 1'b1);
      for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
      chk("tp4_wrap", 32'(out_code), 32'b100000);
      cyc(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 2'b00, 1'b1, 1'b1);
      for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 2'b00, (i == 3) ? 1'b1 : 1'b0, 1'b1);
      chk("tp4_clr_word", 32'(out_code), 32'b100000);
      repeat (2) cyc(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);

      // full-rate push+pop in ONE
      for (int i = 0; i < 11; i++) cyc(1'b1, (i % 3) == 0 ? 1'b1 : 1'b0, 2'(i), 1'b0, 1'b1);
      chk("tp5_ready", 32'(in_ready), 32'd1);
      repeat (2) cyc(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);

      // async reset while TWO
      cyc(1'b1, 1'b0, 2'b01, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 2'b10, 1'b0, 1'b0);
      chk("tp6_full", 32'(in_ready), 32'd0);
      rst_n    = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("tp6_rst_valid", 32'(out_valid), 32'd0);
      chk("tp6_rst_ready", 32'(in_ready), 32'd1);
      chk("tp6_rst_code", 32'(out_code), 32'h00);
      q.delete();
      seq_m  = 0;
      mcnt_m = 0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc(1'b1, 1'b0, 2'b01, 1'b0, 1'b0);
      chk("tp6_seq0", 32'(out_code), 32'b101000);
      repeat (2) cyc(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         cyc(($urandom % 4) != 0, ($urandom % 3) == 0, 2'($urandom % 4),
             ($urandom % 16) == 0, ($urandom % 3) != 0);
      end
      repeat (3) cyc(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);

`ifdef CODE_WORD_TX_STATS_EN
      for (int i = 0; i < 300; i++) cyc(1'b1, 1'b1, 2'b00, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 2'b00, 1'b1, 1'b1);
      chk("stats_sat", 32'(match_cnt), 32'hFF);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
